// File: rtl/bus_pkg.sv
// Shared bus definitions used by the bus master and the register-file slave.
//   - BUS_DATA_WIDTH / BUS_ADDR_WIDTH : default widths of bus_if.
//   - bus_slv_state_t                 : slave handshake state encoding.
//   - cnt_width / idx_width           : width helpers that never return 0,
//                                       so degenerate parameter choices
//                                       (no wait states, one register) still
//                                       produce legal vector declarations.
package bus_pkg;

  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } bus_slv_state_t;

  // Width of a counter that must hold 0..n.
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  // Width of an index that selects one of n entries.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_regfile.sv
// NUM_REGS x DATA_WIDTH register array behind bus_slave_regfile.
// Ports:
//   clk    in  1           clock, rising edge
//   reset  in  1           asynchronous clear, active-low (all entries -> 0)
//   we     in  1           write enable for entry idx
//   idx    in  IDX_W       entry index shared by the write and read ports
//   wdata  in  DATA_WIDTH  write data
//   rdata  out DATA_WIDTH  combinational read of entry idx (0 if idx is past
//                          the last entry, which only happens when NUM_REGS
//                          is not a power of two)
module bus_regfile
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = idx_width(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[idx] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (32'(idx) < NUM_REGS) begin
      rdata = regs[idx];
    end
  end

endmodule

// File: rtl/bus_slave_regfile.sv
// Responder end of bus_if (slave_reg modport). Accepts one request at a time,
// waits WAIT_CYCLES cycles, commits it against the register file and then
// holds the response until the master takes it with ready.
// Ports:
//   clk         in  1           clock, rising edge
//   reset       in  1           asynchronous reset, active-low
//   addr        in  ADDR_WIDTH  word address from master
//   write_data  in  DATA_WIDTH  write data from master
//   write       in  1           1 = write request, 0 = read request
//   valid       in  1           request valid (only looked at while idle)
//   ready       in  1           master takes the response (only looked at
//                               while a response is pending)
//   read        out 1           response valid, for reads and writes alike
//   read_data   out DATA_WIDTH  read result; 0 for writes, for out-of-range
//                               reads and whenever read is low
//   access_err  out 1           one-cycle pulse with the first response cycle
//                               of an out-of-range request
module bus_slave_regfile
  import bus_pkg::*;
#(
  parameter int                  DATA_WIDTH  = BUS_DATA_WIDTH,
  parameter int                  ADDR_WIDTH  = BUS_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write,
  input  logic                  valid,
  input  logic                  ready,
  output logic                  read,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  access_err
);

  localparam int CNT_W = cnt_width(WAIT_CYCLES);
  localparam int IDX_W = idx_width(NUM_REGS);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
  localparam logic [ADDR_WIDTH:0] NUM_REGS_EXT = (ADDR_WIDTH + 1)'(NUM_REGS);

  bus_slv_state_t state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q;

  // Request captured at acceptance; bus inputs are ignored after that.
  logic [ADDR_WIDTH-1:0] lat_addr_q;
  logic [DATA_WIDTH-1:0] lat_wdata_q;
  logic                  lat_write_q;

  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  access_err_q;

  // Request being committed this cycle. With no wait states the commit
  // happens on the accepting edge, so the live bus is used directly;
  // otherwise the latched copy is.
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  c_write;
  logic [ADDR_WIDTH:0]   c_diff;
  logic                  c_hit;
  logic                  wait_last;
  logic                  commit;

  logic                  rf_we;
  logic [IDX_W-1:0]      rf_idx;
  logic [DATA_WIDTH-1:0] rf_rdata;

  assign c_addr  = (state_q == S_IDLE) ? addr       : lat_addr_q;
  assign c_wdata = (state_q == S_IDLE) ? write_data : lat_wdata_q;
  assign c_write = (state_q == S_IDLE) ? write      : lat_write_q;

  // One extra bit catches a borrow, so addresses below BASE_ADDR are rejected
  // instead of wrapping around into the register window.
  assign c_diff = {1'b0, c_addr} - {1'b0, BASE_ADDR};
  assign c_hit  = !c_diff[ADDR_WIDTH] &&
                  ({1'b0, c_diff[ADDR_WIDTH-1:0]} < NUM_REGS_EXT);
  assign rf_idx = c_diff[IDX_W-1:0];

  assign wait_last = (state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST);

  bus_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .idx   (rf_idx),
    .wdata (c_wdata),
    .rdata (rf_rdata)
  );

  // State register and control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      read_data_q  <= '0;
      access_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      access_err_q <= commit && !c_hit;

      if (state_q == S_IDLE) begin
        wait_cnt_q <= '0;
      end else if (state_q == S_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end

      // Cleared on the handshake so read_data is 0 whenever read is low.
      if (commit) begin
        read_data_q <= (!c_write && c_hit) ? rf_rdata : '0;
      end else if ((state_q == S_RESP) && ready) begin
        read_data_q <= '0;
      end
    end
  end

  // Request capture (data path, no reset needed: only read after acceptance)
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && valid) begin
      lat_addr_q  <= addr;
      lat_wdata_q <= write_data;
      lat_write_q <= write;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid)     state_d = ZERO_WAIT ? S_RESP : S_WAIT;
      S_WAIT:  if (wait_last) state_d = S_RESP;
      S_RESP:  if (ready)     state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Outputs and commit strobes
  always_comb begin
    commit     = ((state_q == S_IDLE) && valid && ZERO_WAIT) || wait_last;
    rf_we      = commit && c_write && c_hit;
    read       = (state_q == S_RESP);
    read_data  = read_data_q;
    access_err = access_err_q;
  end

endmodule

// File: tb/tb_bus_slave_regfile.sv
// Bench for bus_slave_regfile: two instances (3 wait states / base 0 / 16 regs,
// and 0 wait states / base 4 / 12 regs), each with a transaction-level
// reference model compared against the outputs on every cycle, plus directed
// literal expectations and randomized traffic.
module tb_bus_slave_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0]       valid, write, ready, read, access_err;
  logic [1:0][15:0] addr;
  logic [1:0][31:0] wdata, read_data;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  for (genvar c = 0; c < 2; c++) begin : g_ch
    localparam int WC = (c == 0) ? 3 : 0;
    localparam int NR = (c == 0) ? 16 : 12;
    localparam int BA = (c == 0) ? 0 : 4;

    bus_slave_regfile #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (16),
      .BASE_ADDR   (16'(BA)),
      .NUM_REGS    (NR),
      .WAIT_CYCLES (WC)
    ) u_dut (
      .clk        (clk),
      .reset      (rst_n[c]),
      .addr       (addr[c]),
      .write_data (wdata[c]),
      .write      (write[c]),
      .valid      (valid[c]),
      .ready      (ready[c]),
      .read       (read[c]),
      .read_data  (read_data[c]),
      .access_err (access_err[c])
    );

    // Reference: a pending request finishes WC edges after acceptance, then a
    // response is held until ready is seen.
    bit [31:0] mregs [16];
    bit        m_busy = 0, m_resp = 0, m_first = 0, m_err = 0;
    int        m_rem = 0;
    bit [31:0] m_rd = 0;
    bit [15:0] m_a;
    bit [31:0] m_wd;
    bit        m_w;

    always @(posedge clk or negedge rst_n[c]) begin
      bit go;
      int off;
      if (!rst_n[c]) begin
        m_busy = 0; m_resp = 0; m_first = 0; m_err = 0; m_rem = 0; m_rd = 0;
        for (int i = 0; i < 16; i++) mregs[i] = 0;
      end else begin
        go = 0;
        m_first = 0;
        if (m_resp) begin
          if (ready[c]) m_resp = 0;
        end else if (m_busy) begin
          m_rem--;
          if (m_rem == 0) go = 1;
        end else if (valid[c]) begin
          m_a = addr[c]; m_wd = wdata[c]; m_w = write[c];
          if (WC == 0) go = 1;
          else begin m_busy = 1; m_rem = WC; end
        end
        if (go) begin
          off = int'(m_a) - BA;
          m_busy = 0; m_resp = 1; m_first = 1;
          m_err = !(off >= 0 && off < NR);
          m_rd = 0;
          if (!m_err) begin
            if (m_w) mregs[off] = m_wd;
            else     m_rd = mregs[off];
          end
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("ch%0d_read", c), 32'(read[c]), 32'(m_resp));
      chk($sformatf("ch%0d_read_data", c), read_data[c], m_resp ? m_rd : 32'd0);
      chk($sformatf("ch%0d_access_err", c), 32'(access_err[c]), 32'(m_resp && m_first && m_err));
    end
  end

  // One request/response; lat counts falling edges from acceptance until read
  // is seen, errs counts access_err cycles, stable reports a constant response
  // during the hold, rel reports read low after the handshake.
  task automatic txn(input int c, input logic [15:0] a, input logic [31:0] wd, input logic w,
                     input int hold, input bit scr,
                     output logic [31:0] data, output int lat, output int errs,
                     output bit stable, output bit rel);
    bit seen;
    @(negedge clk);
    addr[c] = a; wdata[c] = wd; write[c] = w; valid[c] = 1'b1; ready[c] = 1'b0;
    seen = 0; lat = 0; errs = 0; stable = 1; rel = 0; data = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      valid[c] = 1'b0;
      lat++;
      errs += int'(access_err[c]);
      if (read[c] === 1'b1) seen = 1;
      else if (scr) begin
        addr[c] = 16'($urandom); wdata[c] = $urandom; write[c] = 1'($urandom);
      end
    end
    chk($sformatf("ch%0d_resp_seen", c), 32'(seen), 32'd1);
    data = read_data[c];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      errs += int'(access_err[c]);
      if (read[c] !== 1'b1 || read_data[c] !== data) stable = 0;
    end
    ready[c] = 1'b1;
    @(negedge clk);
    ready[c] = 1'b0;
    rel = (read[c] === 1'b0) && (read_data[c] === 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int lat, errs;
    bit st, rel;

    rst_n = 2'b00; valid = '0; write = '0; ready = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      chk($sformatf("ch%0d_reset_read", ch), 32'(read[ch]), 32'd0);
      chk($sformatf("ch%0d_reset_data", ch), read_data[ch], 32'd0);
      chk($sformatf("ch%0d_reset_err", ch), 32'(access_err[ch]), 32'd0);
    end
    #2 rst_n = 2'b11;

    // Instance 0: three wait states
    txn(0, 16'd3, 32'h0000_00A5, 1'b1, 0, 0, d, lat, errs, st, rel);
    chk("wr_resp_data", d, 32'd0);
    chk("wr_latency", 32'(lat), 32'd4);
    txn(0, 16'd3, 32'd0, 1'b0, 0, 0, d, lat, errs, st, rel);
    chk("rd_data", d, 32'h0000_00A5);
    chk("rd_latency", 32'(lat), 32'd4);

    txn(0, 16'd3, 32'd0, 1'b0, 5, 0, d, lat, errs, st, rel);
    chk("bp_data", d, 32'h0000_00A5);
    chk("bp_stable", 32'(st), 32'd1);
    chk("bp_release", 32'(rel), 32'd1);

    txn(0, 16'd16, 32'd0, 1'b0, 2, 0, d, lat, errs, st, rel);
    chk("oor_rd_err_pulses", 32'(errs), 32'd1);
    chk("oor_rd_data", d, 32'd0);
    txn(0, 16'd16, 32'hDEAD_BEEF, 1'b1, 0, 0, d, lat, errs, st, rel);
    chk("oor_wr_err_pulses", 32'(errs), 32'd1);
    for (int i = 0; i < 16; i++) begin
      txn(0, 16'(i), 32'd0, 1'b0, 0, 0, d, lat, errs, st, rel);
      chk($sformatf("readback_%0d", i), d, (i == 3) ? 32'h0000_00A5 : 32'd0);
      chk($sformatf("readback_err_%0d", i), 32'(errs), 32'd0);
    end

    txn(0, 16'd7, 32'h0000_0077, 1'b1, 0, 1, d, lat, errs, st, rel);
    txn(0, 16'd7, 32'd0, 1'b0, 0, 1, d, lat, errs, st, rel);
    chk("latched_req", d, 32'h0000_0077);

    // Reset while a write waits: nothing commits.
    @(negedge clk);
    addr[0] = 16'd5; wdata[0] = 32'h1234_5678; write[0] = 1'b1; valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    #2 rst_n[0] = 1'b0;
    #1 chk("rst_mid_wait_read", 32'(read[0]), 32'd0);
    @(negedge clk);
    #2 rst_n[0] = 1'b1;
    txn(0, 16'd5, 32'd0, 1'b0, 0, 0, d, lat, errs, st, rel);
    chk("rst_no_commit", d, 32'd0);
    txn(0, 16'd3, 32'd0, 1'b0, 0, 0, d, lat, errs, st, rel);
    chk("rst_clears_regs", d, 32'd0);

    // Instance 1: zero wait states, window 4..15
    txn(1, 16'd7, 32'h0000_00A5, 1'b1, 0, 0, d, lat, errs, st, rel);
    chk("w0_wr_data", d, 32'd0);
    chk("w0_wr_latency", 32'(lat), 32'd1);
    txn(1, 16'd7, 32'd0, 1'b0, 1, 0, d, lat, errs, st, rel);
    chk("w0_rd_data", d, 32'h0000_00A5);
    chk("w0_rd_latency", 32'(lat), 32'd1);
    txn(1, 16'd3, 32'd0, 1'b0, 0, 0, d, lat, errs, st, rel);
    chk("w0_below_base_err", 32'(errs), 32'd1);
    txn(1, 16'd16, 32'd0, 1'b0, 0, 0, d, lat, errs, st, rel);
    chk("w0_past_top_err", 32'(errs), 32'd1);
    txn(1, 16'd15, 32'h0000_5A5A, 1'b1, 0, 0, d, lat, errs, st, rel);
    chk("w0_top_wr_err", 32'(errs), 32'd0);
    txn(1, 16'd15, 32'd0, 1'b0, 0, 0, d, lat, errs, st, rel);
    chk("w0_top_rd_data", d, 32'h0000_5A5A);

    // Randomized traffic, checked cycle by cycle against the models
    for (int ch = 0; ch < 2; ch++) begin
      for (int n = 0; n < 120; n++) begin
        txn(ch, 16'($urandom_range(0, 19)), $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), d, lat, errs, st, rel);
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
